sdram_arbit_rr: RTL and testbench

Parametrised SDRAM command arbiter for the multi-port SDRAM controller. It replaces the fixed init/refresh/write/read arbiter with an arbiter for NUM_CH generic requester channels, granted round-robin. Auto-refresh has priority, and a pending refresh is flagged so the active channel can end its burst early. The block sits between the init/aref/channel engines and the SDRAM pins, and drives the DQ bus as separate data and output-enable signals; the top level builds the tristate.

---
 rtl/sdram_arbit_rr_if.sv | 58 +++++
 rtl/sdram_arbit_rr.sv | 162 ++++++++++++++++
 tb/tb_sdram_arbit_rr.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_rr_if.sv
// Signal bundle between the SDRAM command arbiter, its requesting engines and the SDRAM pins.
// The slave modport is the arbiter's view; master is the engine/pin side.
interface sdram_arbit_rr_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
);
    logic [3:0]               init_cmd;
    logic [BA_W-1:0]          init_ba;
    logic [ADDR_W-1:0]        init_addr;
    logic                     init_end;
    logic                     aref_req;
    logic [3:0]               aref_cmd;
    logic [BA_W-1:0]          aref_ba;
    logic [ADDR_W-1:0]        aref_addr;
    logic                     aref_end;
    logic [NUM_CH-1:0]        ch_req;
    logic [4*NUM_CH-1:0]      ch_cmd;
    logic [BA_W*NUM_CH-1:0]   ch_ba;
    logic [ADDR_W*NUM_CH-1:0] ch_addr;
    logic [DATA_W*NUM_CH-1:0] ch_wr_data;
    logic [NUM_CH-1:0]        ch_dq_oe;
    logic [NUM_CH-1:0]        ch_end;

    logic                     aref_en;
    logic [NUM_CH-1:0]        ch_en;
    logic                     aref_pending;
    logic                     sdram_cke;
    logic                     sdram_cs_n;
    logic                     sdram_ras_n;
    logic                     sdram_cas_n;
    logic                     sdram_we_n;
    logic [BA_W-1:0]          sdram_ba;
    logic [ADDR_W-1:0]        sdram_addr;
    logic [DATA_W-1:0]        sdram_dq_out;
    logic                     sdram_dq_oe;
    // Debug view of the arbiter FSM: 0 INIT, 1 ARBIT, 2 AREF, 3 CH.
    logic [1:0]               dbg_state;

    modport slave (
        input  init_cmd, init_ba, init_addr, init_end,
        input  aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
        input  ch_req, ch_cmd, ch_ba, ch_addr, ch_wr_data, ch_dq_oe, ch_end,
        output aref_en, ch_en, aref_pending,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, dbg_state
    );

    modport master (
        output init_cmd, init_ba, init_addr, init_end,
        output aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
        output ch_req, ch_cmd, ch_ba, ch_addr, ch_wr_data, ch_dq_oe, ch_end,
        input  aref_en, ch_en, aref_pending,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, dbg_state
    );
endinterface

// File: rtl/sdram_arbit_rr.sv
// SDRAM command arbiter: init pass-through, then refresh-first arbitration with
// round-robin grants among NUM_CH channels, one NOP cycle between grants.
module sdram_arbit_rr #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    sdram_arbit_rr_if.slave  bus
);
    localparam int         PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ARBIT = 2'd1,
        ST_AREF  = 2'd2,
        ST_CH    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              aref_en_q, aref_en_d;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic [3:0]        sel_cmd;
    logic [BA_W-1:0]   sel_ba;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oe;
    logic              sel_end;

    logic              pick_vld;
    logic [PTR_W-1:0]  pick;
    logic [PTR_W-1:0]  cand;

    logic [3:0]        pin_cmd;
    logic [BA_W-1:0]   pin_ba;
    logic [ADDR_W-1:0] pin_addr;

    // While in CH the pointer holds the granted index, so it selects the channel slice.
    always_comb begin
        sel_cmd   = CMD_NOP;
        sel_ba    = '1;
        sel_addr  = '1;
        sel_wdata = '0;
        sel_oe    = 1'b0;
        sel_end   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                sel_cmd   = bus.ch_cmd[4*i +: 4];
                sel_ba    = bus.ch_ba[BA_W*i +: BA_W];
                sel_addr  = bus.ch_addr[ADDR_W*i +: ADDR_W];
                sel_wdata = bus.ch_wr_data[DATA_W*i +: DATA_W];
                sel_oe    = bus.ch_dq_oe[i];
                sel_end   = bus.ch_end[i];
            end
        end
    end

    // Round-robin search: first requester after the last grant, wrapping at NUM_CH.
    always_comb begin
        pick_vld = 1'b0;
        pick     = ptr_q;
        cand     = ptr_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_CH);
            for (int j = 0; j < NUM_CH; j++) begin
                if (!pick_vld && cand == PTR_W'(j) && bus.ch_req[j]) begin
                    pick_vld = 1'b1;
                    pick     = cand;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        aref_en_d = aref_en_q;
        ch_en_d   = ch_en_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            ST_INIT: begin
                if (bus.init_end) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (bus.aref_req) begin
                    state_d   = ST_AREF;
                    aref_en_d = 1'b1;
                end else if (pick_vld) begin
                    state_d = ST_CH;
                    ptr_d   = pick;
                    for (int i = 0; i < NUM_CH; i++) ch_en_d[i] = (pick == PTR_W'(i));
                end
            end
            ST_AREF: begin
                if (bus.aref_end) begin
                    state_d   = ST_ARBIT;
                    aref_en_d = 1'b0;
                end
            end
            ST_CH: begin
                if (sel_end) begin
                    state_d = ST_ARBIT;
                    ch_en_d = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= ST_INIT;
            aref_en_q <= 1'b0;
            ch_en_q   <= '0;
            ptr_q     <= PTR_W'(NUM_CH - 1);
        end else begin
            state_q   <= state_d;
            aref_en_q <= aref_en_d;
            ch_en_q   <= ch_en_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        pin_cmd  = CMD_NOP;
        pin_ba   = '1;
        pin_addr = '1;
        unique case (state_q)
            ST_INIT: begin
                pin_cmd  = bus.init_cmd;
                pin_ba   = bus.init_ba;
                pin_addr = bus.init_addr;
            end
            ST_AREF: begin
                pin_cmd  = bus.aref_cmd;
                pin_ba   = bus.aref_ba;
                pin_addr = bus.aref_addr;
            end
            ST_CH: begin
                pin_cmd  = sel_cmd;
                pin_ba   = sel_ba;
                pin_addr = sel_addr;
            end
            default: ;
        endcase
    end

    assign bus.sdram_cke    = 1'b1;
    assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = pin_cmd;
    assign bus.sdram_ba     = pin_ba;
    assign bus.sdram_addr   = pin_addr;
    assign bus.sdram_dq_out = (state_q == ST_CH) ? sel_wdata : '0;
    assign bus.sdram_dq_oe  = (state_q == ST_CH) && sel_oe;
    assign bus.aref_en      = aref_en_q;
    assign bus.ch_en        = ch_en_q;
    assign bus.aref_pending = (state_q == ST_CH) && bus.aref_req;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_sdram_arbit_rr.sv
// Bench for sdram_arbit_rr with four channels: directed vector table, a round-robin
// burst sequence, then random traffic against a behavioural arbiter model.
module tb_sdram_arbit_rr;
    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int AW    = 13;
    localparam int BW    = 2;
    localparam int OBS_W = 1 + NCH + 1 + 1 + 4 + BW + AW + DW + 1;
    localparam int CMD_W = 4 * NCH;
    localparam int CBA_W = BW * NCH;
    localparam int CAD_W = AW * NCH;
    localparam int CDT_W = DW * NCH;
    localparam int M_INIT = 0;
    localparam int M_IDLE = 1;
    localparam int M_REF  = 2;
    localparam int M_CH   = 3;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   cyc;
    bit   check_en;

    // Behavioural model: what the arbiter is doing, who holds the grant, who was served last.
    int   m_mode;
    int   m_gnt;
    int   m_last;
    logic [OBS_W-1:0] exp_q[$];

    sdram_arbit_rr_if #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .BA_W(BW)) bus ();

    sdram_arbit_rr #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .BA_W(BW)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic       rst_n;
        logic       init_end;
        logic       aref_req;
        logic       aref_end;
        logic [3:0] req;
        logic [3:0] ends;
        logic [3:0] oe_req;
        logic       e_aref;
        logic [3:0] e_ch;
        logic       e_pend;
        logic [3:0] e_cmd;
        logic       e_oe;
        logic [15:0] e_dq;
    } vec_t;

    vec_t tbl[26];

    function automatic logic [OBS_W-1:0] dut_obs();
        return {bus.aref_en, bus.ch_en, bus.aref_pending, bus.sdram_cke,
                bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                bus.sdram_ba, bus.sdram_addr, bus.sdram_dq_out, bus.sdram_dq_oe};
    endfunction

    function automatic logic [OBS_W-1:0] model_obs();
        logic [3:0]     cmd;
        logic [BW-1:0]  ba;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  dq;
        logic           oe;
        logic [NCH-1:0] chen;
        cmd = 4'b0111; ba = '1; addr = '1; dq = '0; oe = 1'b0; chen = '0;
        if (m_mode == M_INIT) begin
            cmd = bus.init_cmd; ba = bus.init_ba; addr = bus.init_addr;
        end else if (m_mode == M_REF) begin
            cmd = bus.aref_cmd; ba = bus.aref_ba; addr = bus.aref_addr;
        end else if (m_mode == M_CH) begin
            cmd  = bus.ch_cmd[4*m_gnt +: 4];
            ba   = bus.ch_ba[BW*m_gnt +: BW];
            addr = bus.ch_addr[AW*m_gnt +: AW];
            dq   = bus.ch_wr_data[DW*m_gnt +: DW];
            oe   = bus.ch_dq_oe[m_gnt];
            chen[m_gnt] = 1'b1;
        end
        return {(m_mode == M_REF), chen, (m_mode == M_CH) && bus.aref_req, 1'b1,
                cmd, ba, addr, dq, oe};
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_mode = M_INIT;
            m_last = NCH - 1;
        end else if (m_mode == M_INIT) begin
            if (bus.init_end) m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (bus.aref_req) begin
                m_mode = M_REF;
            end else begin
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_last + k) % NCH;
                    if (m_mode == M_IDLE && bus.ch_req[c]) begin
                        m_mode = M_CH;
                        m_gnt  = c;
                        m_last = c;
                    end
                end
            end
        end else if (m_mode == M_REF) begin
            if (bus.aref_end) m_mode = M_IDLE;
        end else begin
            if (bus.ch_end[m_gnt]) m_mode = M_IDLE;
        end
    endtask

    // One clock: scoreboard compare mid-cycle, advance the model, return just after the edge.
    task automatic step();
        logic [OBS_W-1:0] act;
        logic [OBS_W-1:0] e;
        @(negedge clk);
        if (check_en) begin
            exp_q.push_back(model_obs());
            act = dut_obs();
            e   = exp_q.pop_front();
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL model cyc=%0d got=%h exp=%h", cyc, act, e);
            end
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_fixed_data();
        bus.init_cmd   = 4'b0010;
        bus.init_ba    = 2'b00;
        bus.init_addr  = 13'h0400;
        bus.aref_cmd   = 4'b0001;
        bus.aref_ba    = 2'b11;
        bus.aref_addr  = 13'h1abc;
        bus.ch_cmd     = {4'hB, 4'hA, 4'h9, 4'h8};
        bus.ch_ba      = 8'b11_10_01_00;
        bus.ch_addr    = {13'h0333, 13'h0222, 13'h0111, 13'h0aaa};
        bus.ch_wr_data = {16'h3333, 16'h2222, 16'h1111, 16'hA5A5};
    endtask

    task automatic clear_ctrl();
        bus.init_end = 1'b0;
        bus.aref_req = 1'b0;
        bus.aref_end = 1'b0;
        bus.ch_req   = '0;
        bus.ch_end   = '0;
        bus.ch_dq_oe = '0;
    endtask

    task automatic drive_random();
        rst_n          = ($urandom_range(0, 199) != 0);
        bus.init_end   = ($urandom_range(0, 7) == 0);
        bus.aref_req   = ($urandom_range(0, 5) == 0);
        bus.aref_end   = ($urandom_range(0, 2) == 0);
        bus.ch_req     = NCH'($urandom);
        bus.ch_dq_oe   = NCH'($urandom);
        for (int j = 0; j < NCH; j++) bus.ch_end[j] = ($urandom_range(0, 2) == 0);
        bus.init_cmd   = 4'($urandom);
        bus.init_ba    = BW'($urandom);
        bus.init_addr  = AW'($urandom);
        bus.aref_cmd   = 4'($urandom);
        bus.aref_ba    = BW'($urandom);
        bus.aref_addr  = AW'($urandom);
        bus.ch_cmd     = CMD_W'($urandom);
        bus.ch_ba      = CBA_W'($urandom);
        bus.ch_addr    = CAD_W'({$urandom, $urandom});
        bus.ch_wr_data = CDT_W'({$urandom, $urandom});
    endtask

    initial begin
        logic [26:0] t_act;
        logic [26:0] t_exp;
        int          gap;

        n_vec = 0; n_err = 0; cyc = 0; check_en = 1'b0;
        m_mode = M_INIT; m_gnt = 0; m_last = NCH - 1;

        //        rst   ie    ar    ae    req    end    oe   | aref  ch     pend  cmd    oe    dq
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h1, 1'b0, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h1, 1'b0, 16'h0000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 4'h8, 1'b1, 16'hA5A5};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h2, 4'h0, 1'b0, 4'h1, 1'b0, 4'h8, 1'b0, 16'hA5A5};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h1, 4'h0, 1'b0, 4'h1, 1'b0, 4'h8, 1'b0, 16'hA5A5};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h2, 1'b0, 4'h2, 1'b1, 4'h9, 1'b1, 16'h1111};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h2, 4'h0, 1'b0, 4'h2, 1'b1, 4'h9, 1'b0, 16'h1111};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h1, 1'b0, 16'h0000};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 4'h4, 1'b0, 4'h4, 1'b0, 4'hA, 1'b1, 16'h2222};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h8, 4'h0, 1'b0, 4'h8, 1'b0, 4'hB, 1'b0, 16'h3333};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 4'h8, 1'b1, 16'hA5A5};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 16'h0000};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 16'h0000};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};
        tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 1'b0, 4'h1, 1'b0, 4'h8, 1'b0, 16'hA5A5};
        tbl[24] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};
        tbl[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 16'h0000};

        // Clock/reset: hold reset across two edges before any checking.
        rst_n = 1'b0;
        clear_ctrl();
        set_fixed_data();
        step();
        step();
        check_en = 1'b1;

        // Directed vector table: init pass-through, refresh priority, pending refresh, DQ path, reset mid-burst.
        for (int i = 0; i < 26; i++) begin
            rst_n        = tbl[i].rst_n;
            bus.init_end = tbl[i].init_end;
            bus.aref_req = tbl[i].aref_req;
            bus.aref_end = tbl[i].aref_end;
            bus.ch_req   = tbl[i].req;
            bus.ch_end   = tbl[i].ends;
            bus.ch_dq_oe = tbl[i].oe_req;
            #2;
            t_act = {bus.aref_en, bus.ch_en, bus.aref_pending,
                     bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                     bus.sdram_dq_oe, bus.sdram_dq_out};
            t_exp = {tbl[i].e_aref, tbl[i].e_ch, tbl[i].e_pend, tbl[i].e_cmd,
                     tbl[i].e_oe, tbl[i].e_dq};
            n_vec++;
            if (t_act !== t_exp) begin
                n_err++;
                $display("FAIL table row=%0d got=%h exp=%h", i, t_act, t_exp);
            end
            step();
        end

        // Round-robin with all channels requesting and 3-cycle bursts: order 0,1,2,3,0, one NOP between.
        clear_ctrl();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.init_end = 1'b1;
        step();
        bus.init_end = 1'b0;
        bus.ch_req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            logic [3:0] want;
            want = 4'(1 << (n % NCH));
            gap = 0;
            while (bus.ch_en == 4'h0 && gap < 10) begin
                gap++;
                step();
            end
            n_vec++;
            if (gap != 1) begin
                n_err++;
                $display("FAIL rr_gap grant=%0d got=%0d exp=1", n, gap);
            end
            n_vec++;
            if (bus.ch_en !== want) begin
                n_err++;
                $display("FAIL rr_order grant=%0d got=%b exp=%b", n, bus.ch_en, want);
            end
            step();
            step();
            bus.ch_end = want;
            step();
            bus.ch_end = '0;
        end

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            drive_random();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
